rpn_stack_alu: RTL

RPN_STACK_ALU -- requirements
Module: rpn_stack_alu

---
 rtl/rpn_stack_alu.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rpn_stack_alu.sv
// 8-bit RPN stack calculator: push/op commands on a DEPTH-entry stack, with
// single-cycle ADD/SUB/NEG/stack ops and an iterative shift-add MUL.
module rpn_stack_alu #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               data_in,
  input  logic                     op_valid,
  input  logic [2:0]               op_code,
  input  logic                     non_signed,
  output logic [7:0]               top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     top_valid,
  output logic                     busy,
  output logic                     err_underflow,
  output logic                     err_overflow,
  output logic                     arith_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpMul  = 3'd2;
  localparam logic [2:0] OpNeg  = 3'd3;
  localparam logic [2:0] OpDrop = 3'd4;
  localparam logic [2:0] OpSwap = 3'd5;
  localparam logic [2:0] OpDup  = 3'd6;
  localparam logic [2:0] OpClr  = 3'd7;

  typedef enum logic [1:0] {StIdle, StMulRun, StMulDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        stk_q [DEPTH];
  logic [7:0]        stk_d [DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  logic              uf_q, uf_d, ov_q, ov_d, ao_q, ao_d;
  logic [15:0]       mcand_q, mcand_d, acc_q, acc_d;
  logic [7:0]        mplier_q, mplier_d;
  logic              neg_q, neg_d, uns_q, uns_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [AW-1:0]     t_idx, s_idx, p_idx;
  logic [7:0]        t_val, s_val, diff, neg_t, mag_s, mag_t, mul_res;
  logic [8:0]        sum9;
  logic [15:0]       prod_neg;
  logic              full, empty, lt2, mul_ovf;

  always_comb begin
    t_idx    = AW'(depth_q - DW'(1));
    s_idx    = AW'(depth_q - DW'(2));
    p_idx    = AW'(depth_q);
    t_val    = stk_q[t_idx];
    s_val    = stk_q[s_idx];
    full     = (depth_q == DW'(DEPTH));
    empty    = (depth_q == '0);
    lt2      = (depth_q < DW'(2));
    sum9     = {1'b0, s_val} + {1'b0, t_val};
    diff     = s_val - t_val;
    neg_t    = 8'h00 - t_val;
    // Signed magnitudes fit 8 bits unsigned, -128 becomes 8'h80 = 128.
    mag_s    = (!non_signed && s_val[7]) ? 8'h00 - s_val : s_val;
    mag_t    = (!non_signed && t_val[7]) ? neg_t : t_val;
    prod_neg = 16'h0000 - acc_q;
    mul_res  = neg_q ? prod_neg[7:0] : acc_q[7:0];
    mul_ovf  = uns_q ? (acc_q > 16'd255) : (neg_q ? (acc_q > 16'd128) : (acc_q > 16'd127));
  end

  always_comb begin
    state_d  = state_q;
    stk_d    = stk_q;
    depth_d  = depth_q;
    uf_d     = uf_q;
    ov_d     = ov_q;
    ao_d     = ao_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    uns_d    = uns_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (push) begin
          uf_d = 1'b0;
          ao_d = 1'b0;
          ov_d = full;
          if (!full) begin
            stk_d[p_idx] = data_in;
            depth_d      = depth_q + DW'(1);
          end
        end else if (op_valid) begin
          // A legal MUL defers its flag update to StMulDone.
          if (!(op_code == OpMul && !lt2)) begin
            uf_d = 1'b0;
            ov_d = 1'b0;
            ao_d = 1'b0;
          end
          unique case (op_code)
            OpAdd, OpSub: begin
              if (lt2) begin
                uf_d = 1'b1;
              end else begin
                depth_d = depth_q - DW'(1);
                if (op_code == OpAdd) begin
                  stk_d[s_idx] = sum9[7:0];
                  ao_d = non_signed ? sum9[8]
                                    : (s_val[7] == t_val[7]) && (sum9[7] != s_val[7]);
                end else begin
                  stk_d[s_idx] = diff;
                  ao_d = non_signed ? (s_val < t_val)
                                    : (s_val[7] != t_val[7]) && (diff[7] != s_val[7]);
                end
              end
            end
            OpMul: begin
              if (lt2) begin
                uf_d = 1'b1;
              end else begin
                mcand_d  = {8'h00, mag_s};
                mplier_d = mag_t;
                acc_d    = '0;
                neg_d    = !non_signed && (s_val[7] != t_val[7]);
                uns_d    = non_signed;
                cnt_d    = '0;
                state_d  = StMulRun;
              end
            end
            OpNeg: begin
              if (empty) begin
                uf_d = 1'b1;
              end else begin
                stk_d[t_idx] = neg_t;
                ao_d = non_signed ? (t_val != 8'h00) : (t_val == 8'h80);
              end
            end
            OpDrop: begin
              if (empty) uf_d = 1'b1;
              else       depth_d = depth_q - DW'(1);
            end
            OpSwap: begin
              if (lt2) begin
                uf_d = 1'b1;
              end else begin
                stk_d[t_idx] = s_val;
                stk_d[s_idx] = t_val;
              end
            end
            OpDup: begin
              if (empty) begin
                uf_d = 1'b1;
              end else if (full) begin
                ov_d = 1'b1;
              end else begin
                stk_d[p_idx] = t_val;
                depth_d      = depth_q + DW'(1);
              end
            end
            OpClr: depth_d = '0;
            default: ;
          endcase
        end
      end
      StMulRun: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StMulDone;
      end
      StMulDone: begin
        stk_d[s_idx] = mul_res;
        depth_d      = depth_q - DW'(1);
        uf_d         = 1'b0;
        ov_d         = 1'b0;
        ao_d         = mul_ovf;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      depth_q  <= '0;
      uf_q     <= 1'b0;
      ov_q     <= 1'b0;
      ao_q     <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      uns_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      uf_q     <= uf_d;
      ov_q     <= ov_d;
      ao_q     <= ao_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      uns_q    <= uns_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entries above depth are don't-care, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (!rst) stk_q <= stk_d;
  end

  assign top           = empty ? 8'h00 : t_val;
  assign depth         = depth_q;
  assign top_valid     = !empty;
  assign busy          = (state_q != StIdle);
  assign err_underflow = uf_q;
  assign err_overflow  = ov_q;
  assign arith_ovf     = ao_q;

endmodule
